// File: rtl/ip_uart_pkg.sv
// Shared definitions for the I/O-mapped UART receiver.
//   rx_state_e  : receiver FSM encoding
//   ST_*        : bit positions in the status port byte
//   FIFO_DEPTH  : entries in the optional receive FIFO (UART_RX_FIFO_EN)
package ip_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  localparam int ST_READY = 0;
  localparam int ST_OVR   = 1;
  localparam int ST_FERR  = 2;
  localparam int ST_BUSY  = 3;
  localparam int ST_FULL  = 4;

  localparam int FIFO_DEPTH = 4;
endpackage

// File: rtl/ip_uart_rx.sv
// 8N1 serial deserialiser: 2-FF input synchroniser, bit timer and FSM.
// Ports:
//   clk, reset       : clock, async active-high reset
//   uart_rx          : asynchronous serial line (idles high)
//   rx_data[7:0]     : last assembled byte (valid when byte_valid)
//   byte_valid       : 1-clk pulse, good stop bit seen
//   frame_err_pulse  : 1-clk pulse, stop bit sampled low (byte discarded)
//   busy             : FSM not in IDLE
module ip_uart_rx
  import ip_uart_pkg::*;
#(
  parameter int clk_freq  = 27000000,
  parameter int uart_freq = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       frame_err_pulse,
  output logic       busy
);
  localparam int BP   = clk_freq / uart_freq;
  localparam int HALF = BP / 2;
  localparam int CW   = $clog2(BP + 1);
  localparam logic [CW-1:0] BP_M1   = CW'(BP - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  logic [1:0]    sync;
  logic          rx_s;
  rx_state_e     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;

  assign rx_s = sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= 2'b11;
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      sync  <= {sync[0], uart_rx};
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
    end
  end

  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    idx_n           = idx;
    sh_n            = sh;
    byte_valid      = 1'b0;
    frame_err_pulse = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        cnt_n   = HALF_M1;  // land the next samples mid-bit
        state_n = START;
      end
      START: if (cnt == '0) begin
        if (!rx_s) begin
          state_n = DATA;
          cnt_n   = BP_M1;
          idx_n   = '0;
        end else begin
          state_n = IDLE;   // start bit did not survive to mid-bit: glitch
        end
      end else cnt_n = cnt - 1'b1;
      DATA: if (cnt == '0) begin
        sh_n  = {rx_s, sh[7:1]};  // LSB first
        cnt_n = BP_M1;
        idx_n = idx + 3'd1;
        if (idx == 3'd7) state_n = STOP;
      end else cnt_n = cnt - 1'b1;
      STOP: if (cnt == '0) begin
        if (rx_s) byte_valid      = 1'b1;
        else      frame_err_pulse = 1'b1;
        // back to IDLE at mid-stop so a following start edge is not missed
        state_n = IDLE;
      end else cnt_n = cnt - 1'b1;
      default: state_n = IDLE;
    endcase
  end

  assign rx_data = sh;
  assign busy    = (state != IDLE);
endmodule

// File: rtl/ip_uart_rx_inst.sv
// UART receiver peripheral on the Z80-style I/O bus.
//   io_base   : status port (read: {3'b0, full, busy, framing_err, overrun,
//               rx_ready}; write: clears overrun/framing_err)
//   io_base+1 : data port (read pops the byte; writes ignored)
// Ports: clk, reset (async active-high), enable (bus-phase qualifier),
//   iorq_n/wr_n/rd_n/a/d (bus), q/q_en (read data + decode), uart_rx (serial
//   in), rx_int (level IRQ while data pending).
// Build option: define UART_RX_FIFO_EN to replace the single holding register
// with a 4-entry FIFO; status bit 4 then reports FIFO full.
module ip_uart_rx_inst
  import ip_uart_pkg::*;
#(
  parameter int          clk_freq  = 27000000,
  parameter int          uart_freq = 115200,
  parameter logic [7:0]  io_base   = 8'h12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       iorq_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic [7:0] a,
  input  logic [7:0] d,
  output logic [7:0] q,
  output logic       q_en,
  input  logic       uart_rx,
  output logic       rx_int
);
  logic [7:0] rx_data, rd_data, status;
  logic       byte_valid, frame_err_pulse, busy;
  logic       dec_st, dec_dt, ff_rd_n, ff_wr_n, pop, err_clr;
  logic       rx_ready, full, overrun, framing_err, ovr_set;
  logic       unused_d;

  assign unused_d = ^d;  // data-port writes carry no function

  ip_uart_rx #(.clk_freq(clk_freq), .uart_freq(uart_freq)) u_rx (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .rx_data(rx_data),
    .byte_valid(byte_valid), .frame_err_pulse(frame_err_pulse), .busy(busy)
  );

  assign dec_st = !iorq_n && (a == io_base);
  assign dec_dt = !iorq_n && (a == io_base + 8'd1);

  // previous strobe levels give one action per bus cycle however long it is
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_rd_n <= 1'b1;
      ff_wr_n <= 1'b1;
    end else if (enable) begin
      ff_rd_n <= rd_n;
      ff_wr_n <= wr_n;
    end
  end

  assign pop     = enable && dec_dt && !rd_n && ff_rd_n;
  assign err_clr = enable && dec_st && !wr_n && ff_wr_n;

`ifdef UART_RX_FIFO_EN
  logic [7:0] mem [FIFO_DEPTH];
  logic [1:0] wp, rp;
  logic [2:0] count;
  logic       do_pop, push;

  assign full     = (count == 3'(FIFO_DEPTH));
  assign rx_ready = (count != 3'd0);
  assign do_pop   = pop && rx_ready;
  assign push     = byte_valid && (!full || do_pop);
  assign ovr_set  = byte_valid && full && !pop;
  assign rd_data  = mem[rp];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= rx_data;
        wp      <= wp + 2'd1;
      end
      if (do_pop) rp <= rp + 2'd1;
      if (push && !do_pop)      count <= count + 3'd1;
      else if (!push && do_pop) count <= count - 3'd1;
    end
  end
`else
  logic [7:0] data_r;

  assign full    = 1'b0;
  assign ovr_set = byte_valid && rx_ready && !pop;
  assign rd_data = data_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r   <= '0;
      rx_ready <= 1'b0;
    end else if (byte_valid) begin
      // a pop in the same cycle frees the register for the new byte
      if (!rx_ready || pop) begin
        data_r   <= rx_data;
        rx_ready <= 1'b1;
      end
    end else if (pop) begin
      rx_ready <= 1'b0;
    end
  end
`endif

  // a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (ovr_set)      overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
      if (frame_err_pulse) framing_err <= 1'b1;
      else if (err_clr)    framing_err <= 1'b0;
    end
  end

  always_comb begin
    status           = '0;
    status[ST_READY] = rx_ready;
    status[ST_OVR]   = overrun;
    status[ST_FERR]  = framing_err;
    status[ST_BUSY]  = busy;
    status[ST_FULL]  = full;
  end

  always_comb begin
    q = '0;
    if (!rd_n && dec_st)      q = status;
    else if (!rd_n && dec_dt) q = rd_data;
  end

  assign q_en   = (dec_st || dec_dt) && !rd_n;
  assign rx_int = rx_ready;
endmodule

// File: tb/tb_ip_uart_rx_inst.sv
// Directed bench for ip_uart_rx_inst at default parameters (BP = 234).
module tb_ip_uart_rx_inst;
  localparam int BP = 27000000 / 115200;
  // start edge driven after edge P: rx_s low after P+2, START at P+3,
  // mid-start at P+120, 8 data bits, stop sampled at P+2226 -> rx_int then
  localparam int LAT = BP / 2 + 9 * BP + 3;

  logic       clk = 1'b0;
  logic       reset, enable, iorq_n, wr_n, rd_n, uart_rx, q_en, rx_int;
  logic [7:0] a, d, q, v;
  logic       e;
  int         checks = 0;
  int         errors = 0;
  int         lat;

  always #5 clk = ~clk;

  ip_uart_rx_inst dut (
    .clk(clk), .reset(reset), .enable(enable), .iorq_n(iorq_n), .wr_n(wr_n),
    .rd_n(rd_n), .a(a), .d(d), .q(q), .q_en(q_en), .uart_rx(uart_rx),
    .rx_int(rx_int)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    uart_rx = 1'b0; tick(BP);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; tick(BP); end
    uart_rx = stop; tick(BP);
    uart_rx = 1'b1;
  endtask

  task automatic io_rd(input logic [7:0] addr, output logic [7:0] data, output logic en);
    a = addr; iorq_n = 1'b0; rd_n = 1'b0;
    #2; data = q; en = q_en;
    @(posedge clk); #1;
    iorq_n = 1'b1; rd_n = 1'b1; a = 8'h00;
    tick(1);
  endtask

  task automatic io_wr(input logic [7:0] addr, input logic [7:0] val);
    a = addr; d = val; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    iorq_n = 1'b1; wr_n = 1'b1; a = 8'h00;
    tick(1);
  endtask

  task automatic st(input string tag, input logic [7:0] exp);
    logic [7:0] s;
    logic       se;
    io_rd(8'h12, s, se);
    chk(tag, s, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    a = 8'h00; d = 8'h00; uart_rx = 1'b1;
    tick(3);
    chk("rst_rx_int", 8'(rx_int), 8'h00);
    chk("rst_q", q, 8'h00);
    chk("rst_q_en", 8'(q_en), 8'h00);
    reset = 1'b0;
    tick(2);
    st("rst_status", 8'h00);

    // 0xA5 with latency measurement
    fork
      send(8'hA5, 1'b1);
      begin
        lat = 0;
        @(posedge clk); #1;
        while (!rx_int && lat < 3000) begin @(posedge clk); #1; lat++; end
      end
    join
    chk("a5_latency", 8'(lat >= LAT - 2 && lat <= LAT + 2), 8'h01);
    chk("a5_rx_int", 8'(rx_int), 8'h01);
    st("a5_status", 8'h01);
    io_rd(8'h13, v, e);
    chk("a5_data", v, 8'hA5);
    chk("a5_q_en", 8'(e), 8'h01);
    st("a5_status_after", 8'h00);
    chk("a5_rx_int_after", 8'(rx_int), 8'h00);

    // 50-clk low glitch
    @(posedge clk); #1;
    uart_rx = 1'b0; tick(50); uart_rx = 1'b1; tick(10);
    st("glitch_busy", 8'h08);
    tick(300);
    st("glitch_status", 8'h00);
    chk("glitch_rx_int", 8'(rx_int), 8'h00);

    // framing error, then clear by status write
    send(8'h3C, 1'b0);
    tick(300);
    st("ferr_status", 8'h04);
    chk("ferr_rx_int", 8'(rx_int), 8'h00);
    io_wr(8'h12, 8'h00);
    st("ferr_cleared", 8'h00);

    // two frames without a read
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
`ifdef UART_RX_FIFO_EN
    st("two_status", 8'h01);
    io_rd(8'h13, v, e); chk("two_data0", v, 8'h11);
    io_rd(8'h13, v, e); chk("two_data1", v, 8'h22);
    st("two_status_after", 8'h00);
`else
    st("two_status", 8'h03);
    io_rd(8'h13, v, e); chk("two_data0", v, 8'h11);
    st("two_status_popped", 8'h02);
    io_wr(8'h12, 8'h00);
    st("two_status_after", 8'h00);
`endif

    // long read whose single pop coincides with byte_valid of the next frame
    send(8'h33, 1'b1);
    st("coinc_pre", 8'h01);
    fork
      send(8'hC3, 1'b1);
      begin
        @(posedge clk); #1;
        tick(LAT - 1);
        a = 8'h13; iorq_n = 1'b0; rd_n = 1'b0;
        tick(20);
        chk("coinc_q_held", q, 8'hC3);
        iorq_n = 1'b1; rd_n = 1'b1; a = 8'h00;
        tick(1);
      end
    join
    st("coinc_status", 8'h01);
    io_rd(8'h13, v, e); chk("coinc_data", v, 8'hC3);
    st("coinc_status_after", 8'h00);

    // reset mid-frame with flags and a byte pending
    send(8'h3C, 1'b0);
    tick(300);
    send(8'h99, 1'b1);
    st("prereset_status", 8'h05);
    @(posedge clk); #1;
    uart_rx = 1'b0; tick(BP);
    uart_rx = 1'b1; tick(BP); uart_rx = 1'b0; tick(BP);
    uart_rx = 1'b1; tick(BP); uart_rx = 1'b0; tick(BP);
    tick(BP / 2);
    reset = 1'b1; tick(2); reset = 1'b0; uart_rx = 1'b1;
    tick(2);
    chk("midrst_rx_int", 8'(rx_int), 8'h00);
    st("midrst_status", 8'h00);
    io_rd(8'h13, v, e); chk("midrst_data", v, 8'h00);
    tick(50);
    send(8'h5A, 1'b1);
    st("post_status", 8'h01);
    io_rd(8'h13, v, e); chk("post_data", v, 8'h5A);
    st("post_status_after", 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
